// File: rtl/weight_stream_sched.sv
// Replays a kernel coefficient ROM N_PASSES times into a write-only FIFO stream,
// using a one-cycle ROM read pipeline backed by a 2-entry skid buffer.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

module weight_stream_sched #(
  parameter int MEM_SIZE   = 16,
  parameter int DATA_WIDTH = `COEFF_WIDTH,
  parameter int N_PASSES   = 4
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ap_start,
  output logic                        ap_idle,
  output logic                        ap_done,
  output logic [$clog2(MEM_SIZE)-1:0] rom_address,
  output logic                        rom_ce,
  input  logic [DATA_WIDTH-1:0]       rom_q,
  output logic [DATA_WIDTH-1:0]       output_V_din,
  input  logic                        output_V_full_n,
  output logic                        output_V_write
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int PW = $clog2(N_PASSES) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(N_PASSES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [AW-1:0]         addr;
  logic [PW-1:0]         pass;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] skid [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic [2:0]            credit_used;
  logic                  push;
  logic                  pop;
  logic                  issue;

  // A pop this cycle frees a slot in time for a read issued now, which is what
  // keeps the stream at one word per cycle with only two skid entries.
  always_comb begin
    pop         = (count != 2'd0) && output_V_full_n;
    push        = inflight;
    credit_used = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    issue       = (state == RUN) && (credit_used < 3'd2);
    count_next  = count + {1'b0, push} - {1'b0, pop};
  end

  assign rom_ce         = issue;
  assign rom_address    = addr;
  assign output_V_write = pop;
  assign output_V_din   = skid[rd_ptr];
  assign ap_idle        = (state == IDLE);
  assign ap_done        = (state == DONE);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= IDLE;
      addr     <= '0;
      pass     <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      skid[0]  <= '0;
      skid[1]  <= '0;
    end else begin
      inflight <= issue;
      count    <= count_next;
      if (push) begin
        skid[wr_ptr] <= rom_q;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case (state)
        IDLE: begin
          if (ap_start) begin
            addr  <= '0;
            pass  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (addr == LAST_ADDR) begin
              addr <= '0;
              pass <= pass + PW'(1);
              if (pass == LAST_PASS) begin
                state <= DRAIN;
              end
            end else begin
              addr <= addr + AW'(1);
            end
          end
        end
        // Leave as the final word is popped so ap_done follows the last write directly.
        DRAIN: begin
          if (!inflight && (count_next == 2'd0)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_sched.sv
// Scoreboard bench for weight_stream_sched: a 4x2 instance for the main scenarios
// and a 2x1 instance for the minimal-ROM wrap case.
module tb_weight_stream_sched;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  logic start2;
  logic full_n;

  logic          idle, done, ce, wr;
  logic [1:0]    addr;
  logic [DW-1:0] q, din;

  logic          idle2, done2, ce2, wr2;
  logic [0:0]    addr2;
  logic [DW-1:0] q2, din2;

  logic [DW-1:0] rom [4] = '{16'd10, 16'd11, 16'd12, 16'd13};

  always @(posedge clk) if (ce) q <= rom[addr];
  always @(posedge clk) if (ce2) q2 <= rom[{1'b0, addr2}];

  weight_stream_sched #(.MEM_SIZE(4), .DATA_WIDTH(DW), .N_PASSES(2)) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_idle(idle), .ap_done(done),
    .rom_address(addr), .rom_ce(ce), .rom_q(q),
    .output_V_din(din), .output_V_full_n(full_n), .output_V_write(wr)
  );

  weight_stream_sched #(.MEM_SIZE(2), .DATA_WIDTH(DW), .N_PASSES(1)) dut2 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start2), .ap_idle(idle2), .ap_done(done2),
    .rom_address(addr2), .rom_ce(ce2), .rom_q(q2),
    .output_V_din(din2), .output_V_full_n(full_n), .output_V_write(wr2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_q2[$];
  int n_wr, n_ce, n_done, n_extra, n_badwr, outstanding, max_out;
  int n_wr2, n_ce2, n_done2, n_extra2;
  int first_ce_cyc, first_wr_cyc, last_wr_cyc, done_cyc;
  logic s_idle, s_wr, s_ce, s_done;
  logic [DW-1:0] s_din;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample and score on the falling edge, return just after the rising edge.
  task step();
    @(negedge clk);
    cyc++;
    s_idle = idle;
    s_wr   = wr;
    s_ce   = ce;
    s_done = done;
    s_din  = din;
    if (rst) begin
      exp_q.delete();
      exp_q2.delete();
      outstanding = 0;
    end else begin
      if (ce) begin
        n_ce++;
        outstanding++;
        if (first_ce_cyc < 0) first_ce_cyc = cyc;
      end
      if (wr) begin
        n_wr++;
        outstanding--;
        if (!full_n) n_badwr++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (exp_q.size() > 0) checkOutput("din", din, exp_q.pop_front());
        else n_extra++;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (ce2) n_ce2++;
      if (wr2) begin
        n_wr2++;
        if (exp_q2.size() > 0) checkOutput("din2", din2, exp_q2.pop_front());
        else n_extra2++;
      end
      if (done2) n_done2++;
    end
    @(posedge clk);
    #1;
  endtask

  task clear_stats();
    n_wr = 0; n_ce = 0; n_done = 0; n_extra = 0; n_badwr = 0; max_out = 0; outstanding = 0;
    n_wr2 = 0; n_ce2 = 0; n_done2 = 0; n_extra2 = 0;
    first_ce_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
  endtask

  task automatic push_run();
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 4; a++)
        exp_q.push_back(rom[a]);
  endtask

  task applyStimulus();
    push_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int want, input int limit);
    int k = 0;
    while (n_done < want && k < limit) begin
      step();
      k++;
    end
    checkOutput("done_count", n_done, want);
  endtask

  task automatic wait_writes(input int want, input int limit);
    int k = 0;
    while (n_wr < want && k < limit) begin
      step();
      k++;
    end
    checkOutput("write_wait", n_wr, want);
  endtask

  task check_run(input int words);
    checkOutput("words", n_wr, words);
    checkOutput("ce_count", n_ce, words);
    checkOutput("queue_left", exp_q.size(), 0);
    checkOutput("extra_writes", n_extra, 0);
    checkOutput("write_while_full", n_badwr, 0);
    checkOutput("outstanding_le2", (max_out <= 2), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; full_n = 1'b1;
    clear_stats();
    step();
    step();
    rst = 1'b0;
    step();
    checkOutput("rst_idle", s_idle, 1);
    checkOutput("rst_write", s_wr, 0);
    checkOutput("rst_ce", s_ce, 0);
    checkOutput("rst_done", s_done, 0);
    checkOutput("rst_din", s_din, 0);

    // Basic streaming with timing
    clear_stats();
    applyStimulus();
    wait_done(1, 40);
    check_run(8);
    checkOutput("read_to_write", first_wr_cyc - first_ce_cyc, 2);
    checkOutput("consecutive", last_wr_cyc - first_wr_cyc, 7);
    checkOutput("done_after_last", done_cyc - last_wr_cyc, 1);
    step();
    checkOutput("idle_after_done", s_idle, 1);
    checkOutput("done_pulse_once", n_done, 1);

    // Backpressure for 5 cycles from the second write
    clear_stats();
    applyStimulus();
    wait_writes(1, 20);
    full_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("hold_din", s_din, 11);
      checkOutput("hold_write", s_wr, 0);
    end
    full_n = 1'b1;
    wait_done(1, 40);
    check_run(8);

    // Alternating backpressure
    clear_stats();
    applyStimulus();
    for (int k = 0; k < 80 && n_done < 1; k++) begin
      full_n = (k % 2 == 0);
      step();
    end
    full_n = 1'b1;
    checkOutput("toggle_done", n_done, 1);
    check_run(8);

    // Reset mid-run after the third write
    clear_stats();
    applyStimulus();
    wait_writes(3, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checkOutput("mid_rst_idle", s_idle, 1);
    checkOutput("mid_rst_write", s_wr, 0);
    checkOutput("mid_rst_ce", s_ce, 0);
    checkOutput("mid_rst_din", s_din, 0);
    repeat (3) step();
    checkOutput("mid_rst_no_writes", n_wr, 3);
    clear_stats();
    applyStimulus();
    wait_done(1, 40);
    check_run(8);

    // Start pulsed mid-run is ignored
    clear_stats();
    applyStimulus();
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, 40);
    repeat (4) step();
    checkOutput("ignored_start_idle", s_idle, 1);
    checkOutput("ignored_start_done", n_done, 1);
    check_run(8);

    // Start held high across DONE gives back-to-back runs
    clear_stats();
    push_run();
    push_run();
    start = 1'b1;
    wait_done(1, 40);
    step();
    checkOutput("b2b_idle", s_idle, 1);
    checkOutput("b2b_idle_ce", s_ce, 0);
    step();
    checkOutput("b2b_run", s_idle, 0);
    checkOutput("b2b_run_ce", s_ce, 1);
    start = 1'b0;
    wait_done(2, 60);
    check_run(16);

    // Minimal ROM, single pass
    clear_stats();
    exp_q2.push_back(rom[0]);
    exp_q2.push_back(rom[1]);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k < 30 && n_done2 < 1; k++) step();
    repeat (4) step();
    checkOutput("small_done", n_done2, 1);
    checkOutput("small_words", n_wr2, 2);
    checkOutput("small_reads", n_ce2, 2);
    checkOutput("small_queue_left", exp_q2.size(), 0);
    checkOutput("small_extra", n_extra2, 0);
    checkOutput("small_idle", idle2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_stream_sched.md
WEIGHT_STREAM_SCHED -- requirements
Module: weight_stream_sched

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 16, meaning words in the kernel coefficient ROM (at least 2).
REQ-002 SHALL have parameter DATA_WIDTH, default `coeff_width, meaning coefficient width in bits.
REQ-003 SHALL have parameter N_PASSES, default 4, meaning full kernel replays per start (at least 1).
REQ-004 SHALL provide the following ports; the block has one clock, and reset is synchronous and active-high:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  start request, sampled in IDLE only.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse on completion.
- rom_address  out  $clog2(MEM_SIZE)  ROM read address.
- rom_ce  out  1  ROM read enable.
- rom_q  in  DATA_WIDTH  ROM data, valid one cycle after rom_ce.
- output_V_din  out  DATA_WIDTH  stream data.
- output_V_full_n  in  1  downstream FIFO not full.
- output_V_write  out  1  stream write strobe.

Function
REQ-005 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-006 IDLE -> RUN when ap_start is high; the address counter and pass counter SHALL both load 0.
REQ-007 In RUN the block SHALL issue one read per cycle (rom_ce=1) whenever skid occupancy plus in-flight reads is below 2.
- This is the credit rule.
- rom_address SHALL be driven by the address counter.
REQ-008 The address counter SHALL increment on each issued read and wrap from MEM_SIZE-1 to 0; the pass counter SHALL increment on that wrap.
REQ-009 The read issued at address MEM_SIZE-1 of pass N_PASSES-1 SHALL be the last read; RUN -> DRAIN on the same edge.
REQ-010 rom_q SHALL be captured into a 2-entry FIFO skid buffer exactly one cycle after each issued read.
- Capture is unconditional; the credit rule guarantees a free entry.
REQ-011 output_V_write SHALL equal (skid not empty AND output_V_full_n); output_V_din SHALL equal the skid head, held stable while output_V_full_n is low.
REQ-012 A skid capture and a pop in the same cycle SHALL leave occupancy unchanged with order preserved; no word SHALL be lost, duplicated or reordered.
REQ-013 Read-to-write latency SHALL be 2 cycles with output_V_full_n high and the skid empty.
- Throughput SHALL be 1 word/cycle sustained.
REQ-014 DRAIN -> DONE when the skid is empty and no read is in flight; DONE SHALL assert ap_done for one cycle and return to IDLE.
REQ-015 Total words written per start SHALL be exactly MEM_SIZE*N_PASSES, in order addr 0..MEM_SIZE-1 repeated.
REQ-016 ap_start SHALL be ignored outside IDLE.
- ap_start held high in IDLE after DONE SHALL begin a new run on the next cycle.
REQ-017 rom_ce SHALL be 0 in IDLE, DRAIN and DONE.
- rom_address SHALL be don't-care when rom_ce=0, but SHALL be driven to a known value (the counter).

Reset
REQ-018 ap_rst high at a clock edge SHALL force the following values in every state, including mid-RUN:
- state IDLE, counters 0, skid empty, in-flight flag 0.
- rom_ce=0, output_V_write=0, ap_done=0, ap_idle=1.
- The returning rom_q of a read issued the cycle before reset SHALL be discarded.
REQ-019 output_V_din SHALL reset to 0.

Verification
REQ-020 MEM_SIZE=4, N_PASSES=2, ROM={10,11,12,13}, full_n=1, start pulse -> writes 10,11,12,13,10,11,12,13 on 8 consecutive cycles; first write 2 cycles after first rom_ce; ap_done 1 cycle after last write (last write, DRAIN->DONE, then pulse).
REQ-021 Same setup, full_n low for 5 cycles starting at the 2nd write -> din held at 11 and no rom_ce beyond 2 outstanding; exact sequence preserved, total 8 words.
REQ-022 full_n toggling 1,0,1,0 each cycle -> 8 words in order, one write per high cycle, no duplicates.
REQ-023 ap_rst asserted for 1 cycle after the 3rd write -> next cycle ap_idle=1, write=0, rom_ce=0; a new start yields a full fresh sequence from 10.
REQ-024 ap_start pulsed mid-RUN -> ignored, exactly 8 words and 1 ap_done; start held high across DONE -> back-to-back runs of 8 words each.
REQ-025 MEM_SIZE=2, N_PASSES=1 -> words {ROM[0],ROM[1]}, ap_done once; address wrap at 1 -> 0 not followed by any extra read.
